mips_mc_controller: RTL

- Multicycle MIPS control FSM. Sequences one shared ALU, one unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles.
- Decodes the same six opcodes as the single-cycle decoder: R-type, LW, SW, BEQ, ADDI, J.
- Sits between the instruction register (opcode, ALU zero flag) and the multicycle datapath muxes/enables. Waits on a memory ready handshake.

---
 rtl/mips_mc_controller_pkg.sv | 97 +++++++++
 rtl/mips_mc_controller_mem_wait.sv | 42 ++++
 rtl/mips_mc_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_pkg.sv
// Multicycle MIPS control definitions: opcodes, ALU operation codes,
// datapath mux selects, FSM state encoding and the per-state control words.
package mips_mc_controller_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_J     = 6'h02,
      OP_BEQ   = 6'h04,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_t;

   typedef enum logic [1:0] {
      ADD_Op    = 2'd0,
      SUB_Op    = 2'd1,
      R_Type_Op = 2'd2,
      ERR_Op    = 2'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_SRC_ALU    = 2'd0,
      PC_SRC_ALUOUT = 2'd1,
      PC_SRC_JUMP   = 2'd2
   } pc_src_t;

   typedef enum logic [1:0] {
      SRC_B_REG     = 2'd0,
      SRC_B_FOUR    = 2'd1,
      SRC_B_IMM     = 2'd2,
      SRC_B_IMM_SH2 = 2'd3
   } alu_src_b_t;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC, S_ALU_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP, S_ERROR
   } mc_state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      pc_src_t    pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      alu_src_b_t alu_src_b;
      alu_op_t    alu_op;
      logic       instr_done;
   } mc_control_t;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;

   // ir_write/pc_write in FETCH and instr_done in MEM_WRITE are further
   // qualified by mem_ready in the top; the table holds their intent.
   //                                       pw pwc pc_src         iord mrd mwr irw rw dst m2r srcA srcB           alu_op     done
   localparam mc_control_t OFF_Ctrl       = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  N, N,  N,  N,   SRC_B_REG,     ERR_Op,    N};
   localparam mc_control_t FETCH_Ctrl     = '{Y, N, PC_SRC_ALU,    N,  Y,  N,  Y,  N, N,  N,  N,   SRC_B_FOUR,    ADD_Op,    N};
   localparam mc_control_t DECODE_Ctrl    = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  N, N,  N,  N,   SRC_B_IMM_SH2, ADD_Op,    N};
   localparam mc_control_t MEM_ADDR_Ctrl  = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  N, N,  N,  Y,   SRC_B_IMM,     ADD_Op,    N};
   localparam mc_control_t MEM_READ_Ctrl  = '{N, N, PC_SRC_ALU,    Y,  Y,  N,  N,  N, N,  N,  N,   SRC_B_REG,     ADD_Op,    N};
   localparam mc_control_t MEM_WB_Ctrl    = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  Y, N,  Y,  N,   SRC_B_REG,     ADD_Op,    Y};
   localparam mc_control_t MEM_WRITE_Ctrl = '{N, N, PC_SRC_ALU,    Y,  N,  Y,  N,  N, N,  N,  N,   SRC_B_REG,     ADD_Op,    Y};
   localparam mc_control_t EXEC_Ctrl      = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  N, N,  N,  Y,   SRC_B_REG,     R_Type_Op, N};
   localparam mc_control_t ALU_WB_Ctrl    = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  Y, Y,  N,  N,   SRC_B_REG,     ADD_Op,    Y};
   localparam mc_control_t ADDI_EXEC_Ctrl = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  N, N,  N,  Y,   SRC_B_IMM,     ADD_Op,    N};
   localparam mc_control_t ADDI_WB_Ctrl   = '{N, N, PC_SRC_ALU,    N,  N,  N,  N,  Y, N,  N,  N,   SRC_B_REG,     ADD_Op,    Y};
   localparam mc_control_t BRANCH_Ctrl    = '{N, Y, PC_SRC_ALUOUT, N,  N,  N,  N,  N, N,  N,  Y,   SRC_B_REG,     SUB_Op,    Y};
   localparam mc_control_t JUMP_Ctrl      = '{Y, N, PC_SRC_JUMP,   N,  N,  N,  N,  N, N,  N,  N,   SRC_B_REG,     ADD_Op,    Y};

   // Control word for a state; IDLE, ERROR and unused codes are all-off.
   function automatic mc_control_t state_ctrl(mc_state_t s);
      mc_control_t c;
      case (s)
         S_FETCH:     c = FETCH_Ctrl;
         S_DECODE:    c = DECODE_Ctrl;
         S_MEM_ADDR:  c = MEM_ADDR_Ctrl;
         S_MEM_READ:  c = MEM_READ_Ctrl;
         S_MEM_WB:    c = MEM_WB_Ctrl;
         S_MEM_WRITE: c = MEM_WRITE_Ctrl;
         S_EXEC:      c = EXEC_Ctrl;
         S_ALU_WB:    c = ALU_WB_Ctrl;
         S_ADDI_EXEC: c = ADDI_EXEC_Ctrl;
         S_ADDI_WB:   c = ADDI_WB_Ctrl;
         S_BRANCH:    c = BRANCH_Ctrl;
         S_JUMP:      c = JUMP_Ctrl;
         default:     c = OFF_Ctrl;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_mc_controller_mem_wait.sv
// Memory handshake watchdog: counts cycles spent waiting on mem_ready in a
// memory state and flags success (ready seen) or timeout (budget exhausted).
module mips_mc_mem_wait #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic ready_i,
   output logic success_o,
   output logic timeout_o
);

   localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Counter sits at zero outside memory states, so every entry starts fresh.
   always_comb begin
      count_d = count_q;
      if (!active_i || ready_i) begin
         count_d = '0;
      end else begin
         count_d = count_q + 8'd1;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign success_o = active_i & ready_i;
   // Ready arriving on the last allowed cycle still wins over the timeout.
   assign timeout_o = active_i & ~ready_i & (count_q == LAST_WAIT);

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM. Outputs are decoded from the current state
// (held as a registered control word); only the memory-handshake strobes are
// qualified by mem_ready. Optional macro MIPS_MC_PERF_COUNTERS_EN adds
// cycle/instruction/stall counters.
module mips_mc_controller
   import mips_mc_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT       = 16,
   parameter bit          RESET_STATE_FETCH = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  opcode_t     opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_src,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output alu_op_t     alu_op,
   output logic        instr_done,
   output logic        illegal
`ifdef MIPS_MC_PERF_COUNTERS_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count,
   output logic [31:0] stall_count
`endif
);

   localparam mc_state_t RST_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

   mc_state_t   state_q, state_d;
   logic        illegal_q, illegal_d;
   mc_control_t ctrl_q;
   logic        mem_active, mem_success, mem_timeout, hs_ok;

   // The branch decision on zero is made in the datapath via pc_write_cond.
   logic unused_zero;
   assign unused_zero = zero;

   assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);

   mips_mc_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk       (clk),
      .rst       (rst),
      .active_i  (mem_active),
      .ready_i   (mem_ready),
      .success_o (mem_success),
      .timeout_o (mem_timeout)
   );

   // Next-state selection; opcode matters only in DECODE and MEM_ADDR.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (mem_success) begin
               state_d = S_DECODE;
            end else if (mem_timeout) begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_ERROR;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (opcode == OP_LW) begin
               state_d = S_MEM_READ;
            end else if (opcode == OP_SW) begin
               state_d = S_MEM_WRITE;
            end else begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end
         end
         S_MEM_READ, S_MEM_WRITE: begin
            if (mem_success) begin
               state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
            end else if (mem_timeout) begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end
         end
         S_EXEC:      state_d = S_ALU_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_ERROR:     state_d = S_ERROR;
         default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
         end
      endcase
   end

   // State, sticky illegal flag and the registered control word of the new state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RST_STATE;
         illegal_q <= 1'b0;
         ctrl_q    <= state_ctrl(RST_STATE);
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         ctrl_q    <= state_ctrl(state_d);
      end
   end

   // Strobes that complete a memory access fire only once the access is accepted.
   assign hs_ok = ~mem_active | mem_ready;

   assign pc_write      = ctrl_q.pc_write & hs_ok;
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign pc_src        = ctrl_q.pc_src;
   assign iord          = ctrl_q.iord;
   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign ir_write      = ctrl_q.ir_write & hs_ok;
   assign reg_write     = ctrl_q.reg_write;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign instr_done    = ctrl_q.instr_done & hs_ok;
   assign illegal       = illegal_q;

`ifdef MIPS_MC_PERF_COUNTERS_EN
   logic [31:0] cycle_q, instr_q, stall_q;

   // Free-running observation counters; they never feed back into the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
         stall_q <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_ERROR) cycle_q <= cycle_q + 32'd1;
         if (instr_done)                             instr_q <= instr_q + 32'd1;
         if (mem_active && !mem_ready)               stall_q <= stall_q + 32'd1;
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
   assign stall_count = stall_q;
`endif

endmodule
